// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and access size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-ported memory; data has priority.
// Optional fetch anti-starvation counter enabled by defining ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight, grant on masked requests
// DBUSY | data access presented to memory, waiting for MemAck
// IBUSY | fetch access presented to memory, waiting for MemAck
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRData,
    output logic              IDone,
    output logic              IStall,
    input  logic              DReq,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    input  logic              DWE,
    input  logic [1:0]        DSize,
    input  logic              DSign,
    output logic [DATA_W-1:0] DRData,
    output logic              DDone,
    output logic              DStall,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWE,
    output logic [1:0]        MemSize,
    output logic              MemSign,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData
);

    arb_state_t state;
    logic       d_req_m;
    logic       i_req_m;
    logic       grant_d;
    logic       grant_i;

    assign IStall = IReq & ~IDone;
    assign DStall = DReq & ~DDone;

    // A requester still holds Req during its own Done cycle, so mask it there.
    assign d_req_m = DReq & ~DDone;
    assign i_req_m = IReq & ~IDone;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = i_req_m && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign grant_d = d_req_m & ~starved;
    assign grant_i = i_req_m & ~grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!IReq) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_i) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_d && i_req_m &&
                     starve_cnt < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign grant_d = d_req_m;
    assign grant_i = i_req_m & ~d_req_m;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            MemReq   <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWE    <= 1'b0;
            MemSize  <= 2'b00;
            MemSign  <= 1'b0;
            IRData   <= '0;
            DRData   <= '0;
            IDone    <= 1'b0;
            DDone    <= 1'b0;
        end else begin
            IDone <= 1'b0;
            DDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        MemReq   <= 1'b1;
                        MemAddr  <= DAddr;
                        MemWData <= DWData;
                        MemWE    <= DWE;
                        MemSize  <= DSize;
                        MemSign  <= DSign;
                        state    <= DBUSY;
                    end else if (grant_i) begin
                        MemReq   <= 1'b1;
                        MemAddr  <= IAddr;
                        MemWData <= '0;
                        MemWE    <= 1'b0;
                        MemSize  <= SIZE_WORD;
                        MemSign  <= 1'b0;
                        state    <= IBUSY;
                    end
                end
                DBUSY: begin
                    if (MemAck) begin
                        DRData <= MemRData;
                        DDone  <= 1'b1;
                        MemReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                IBUSY: begin
                    if (MemAck) begin
                        IRData <= MemRData;
                        IDone  <= 1'b1;
                        MemReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    MemReq <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the memory by driving MemAck by hand.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IDone;
    logic        IStall;
    logic        DReq;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic        DWE;
    logic [1:0]  DSize;
    logic        DSign;
    logic [31:0] DRData;
    logic        DDone;
    logic        DStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemWE;
    logic [1:0]  MemSize;
    logic        MemSign;
    logic        MemAck;
    logic [31:0] MemRData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr [4];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .IReq(IReq),
        .IAddr(IAddr),
        .IRData(IRData),
        .IDone(IDone),
        .IStall(IStall),
        .DReq(DReq),
        .DAddr(DAddr),
        .DWData(DWData),
        .DWE(DWE),
        .DSize(DSize),
        .DSign(DSign),
        .DRData(DRData),
        .DDone(DDone),
        .DStall(DStall),
        .MemReq(MemReq),
        .MemAddr(MemAddr),
        .MemWData(MemWData),
        .MemWE(MemWE),
        .MemSize(MemSize),
        .MemSign(MemSign),
        .MemAck(MemAck),
        .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        IReq = 0; IAddr = '0; DReq = 0; DAddr = '0; DWData = '0;
        DWE = 0; DSize = 2'b00; DSign = 0; MemAck = 0; MemRData = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_memreq", MemReq, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_memsize", MemSize, 0);
        check("rst_idone", IDone, 0);
        check("rst_ddone", DDone, 0);
        check("rst_irdata", IRData, 0);
        check("rst_drdata", DRData, 0);

        // Fetch, memory acks in the third MemReq cycle.
        IReq = 1; IAddr = 32'h100;
        #1;
        check("f_istall_pend", IStall, 1);
        tick();
        check("f_memreq", MemReq, 1);
        check("f_memaddr", MemAddr, 32'h100);
        check("f_memwe", MemWE, 0);
        check("f_memsize", MemSize, 2'b10);
        tick();
        tick();
        check("f_memreq_held", MemReq, 1);
        check("f_istall_wait", IStall, 1);
        check("f_idone_early", IDone, 0);
        MemAck = 1; MemRData = 32'hDEADBEEF;
        tick();
        MemAck = 0;
        check("f_idone", IDone, 1);
        check("f_irdata", IRData, 32'hDEADBEEF);
        check("f_istall_done", IStall, 0);
        check("f_memreq_clr", MemReq, 0);
        IReq = 0;
        tick();
        check("f_idone_pulse", IDone, 0);
        check("f_irdata_hold", IRData, 32'hDEADBEEF);

        // Simultaneous store and fetch: store first, fetch granted in the DDone cycle.
        IReq = 1; IAddr = 32'h104;
        DReq = 1; DAddr = 32'h200; DWE = 1; DWData = 32'h12345678; DSize = 2'b00; DSign = 0;
        tick();
        check("b2b_st_memreq", MemReq, 1);
        check("b2b_st_addr", MemAddr, 32'h200);
        check("b2b_st_we", MemWE, 1);
        check("b2b_st_wdata", MemWData, 32'h12345678);
        check("b2b_st_size", MemSize, 2'b00);
        check("b2b_istall", IStall, 1);
        MemAck = 1; MemRData = 32'h0;
        tick();
        MemAck = 0;
        check("b2b_ddone", DDone, 1);
        check("b2b_idle_cycle", MemReq, 0);
        DReq = 0; DWE = 0;
        tick();
        check("b2b_ddone_pulse", DDone, 0);
        check("b2b_f_memreq", MemReq, 1);
        check("b2b_f_addr", MemAddr, 32'h104);
        check("b2b_f_we", MemWE, 0);
        check("b2b_f_size", MemSize, 2'b10);
        MemAck = 1; MemRData = 32'hCAFEF00D;
        tick();
        MemAck = 0;
        check("b2b_idone", IDone, 1);
        check("b2b_irdata", IRData, 32'hCAFEF00D);
        IReq = 0;
        tick();

        // Load with immediate ack: DDone two edges after the request is seen.
        DReq = 1; DAddr = 32'h300; DWE = 0; DSize = 2'b01; DSign = 1;
        tick();
        check("ld_memreq", MemReq, 1);
        check("ld_size", MemSize, 2'b01);
        check("ld_sign", MemSign, 1);
        check("ld_we", MemWE, 0);
        check("ld_ddone_early", DDone, 0);
        MemAck = 1; MemRData = 32'h000000FF;
        tick();
        MemAck = 0;
        check("ld_ddone", DDone, 1);
        check("ld_drdata", DRData, 32'h000000FF);
        check("ld_dstall", DStall, 0);
        DReq = 0;
        tick();
        check("ld_ddone_pulse", DDone, 0);

        // Reset in DBUSY abandons the access.
        DReq = 1; DAddr = 32'h400; DWE = 1; DWData = 32'hA5A5A5A5; DSize = 2'b10; DSign = 0;
        tick();
        check("rb_memreq", MemReq, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rb_memreq_async", MemReq, 0);
        DReq = 0; DWE = 0;
        tick();
        check("rb_no_ddone", DDone, 0);
        reset = 1'b0;
        tick();
        check("rb_idle", MemReq, 0);
        DReq = 1; DAddr = 32'h404; DWE = 0;
        tick();
        check("rb_new_memreq", MemReq, 1);
        check("rb_new_addr", MemAddr, 32'h404);
        MemAck = 1; MemRData = 32'h000055AA;
        tick();
        MemAck = 0;
        check("rb_new_ddone", DDone, 1);
        check("rb_new_drdata", DRData, 32'h000055AA);
        DReq = 0;
        tick();

        // Both held continuously: the Done mask hands the port to the other side each time.
        exp_addr[0] = 32'h600; exp_addr[1] = 32'h500;
        exp_addr[2] = 32'h600; exp_addr[3] = 32'h500;
        IReq = 1; IAddr = 32'h500;
        DReq = 1; DAddr = 32'h600; DWE = 0; DSize = 2'b10; DSign = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_addr%0d", i), MemAddr, exp_addr[i]);
            check($sformatf("alt_req%0d", i), MemReq, 1);
            MemAck = 1; MemRData = 32'h1000 + 32'(i);
            tick();
            MemAck = 0;
            check($sformatf("alt_ddone%0d", i), DDone, (i % 2 == 0) ? 1 : 0);
            check($sformatf("alt_idone%0d", i), IDone, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        check("alt_last_addr", MemAddr, 32'h600);
        IReq = 0; DReq = 0;
        MemAck = 1; MemRData = 32'h00007777;
        tick();
        MemAck = 0;
        check("alt_last_ddone", DDone, 1);
        check("alt_last_drdata", DRData, 32'h00007777);
        check("alt_irdata", IRData, 32'h00001003);
        tick();

        // Stray MemAck in IDLE is ignored.
        MemAck = 1; MemRData = 32'h00000BAD;
        tick();
        MemAck = 0;
        check("stray_idone", IDone, 0);
        check("stray_ddone", DDone, 0);
        check("stray_memreq", MemReq, 0);
        check("stray_drdata", DRData, 32'h00007777);
        check("stray_irdata", IRData, 32'h00001003);
        tick();
        check("stray_idle", MemReq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
